// File: rtl/tc_pkg.sv
// Shared types and default constants for the antenna time-constant excitation path.
// The measurement block imports TC_CHARGE_MAX from here so both sides agree on the
// charge-phase timeout.
package tc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDeadC,
        StCharge,
        StDeadD,
        StDischarge
    } tc_state_e;

    localparam int unsigned TC_CHARGE_MAX  = 4095;
    localparam int unsigned TC_DEAD_CYCLES = 4;
    localparam int unsigned TC_DIS_CYCLES  = 1000;
    localparam int unsigned TC_DIS_MAX     = 8191;

    // Width needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; both flops clear to 0
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tc_excite.sv
// Antenna RC excitation sequencer. Repeats charge -> dead time -> discharge -> dead time
// while enable is high. The ant_out rising edge is the start event for the measurement
// block; charge ends on meas_valid, on enable dropping, or on a timeout.
// Ports:
//   clk_100    - 100 MHz system clock
//   reset      - synchronous, active-high
//   enable     - run continuous excitation cycles while high
//   ant_in     - asynchronous comparator output, high = threshold crossed
//   meas_valid - one-cycle pulse: charge result captured by the measurement block
//   ant_out    - charge drive (registered)
//   ant_dis    - discharge drive, high = pull antenna to ground (registered)
//   busy       - high in every state except idle
//   timeout    - one-cycle pulse, first cycle after a charge that hit CHARGE_MAX
//   dis_fault  - one-cycle pulse, first cycle after a discharge that hit DIS_MAX
//                with the antenna still above threshold
//   cycle_cnt  - completed excitation cycles, wraps
module tc_excite
    import tc_pkg::*;
#(
    parameter int unsigned CHARGE_MAX  = TC_CHARGE_MAX,
    parameter int unsigned DEAD_CYCLES = TC_DEAD_CYCLES,
    parameter int unsigned DIS_CYCLES  = TC_DIS_CYCLES,
    parameter int unsigned DIS_MAX     = TC_DIS_MAX,
    parameter int unsigned CNT_BITS    = 16
) (
    input  logic                clk_100,
    input  logic                reset,
    input  logic                enable,
    input  logic                ant_in,
    input  logic                meas_valid,
    output logic                ant_out,
    output logic                ant_dis,
    output logic                busy,
    output logic                timeout,
    output logic                dis_fault,
    output logic [CNT_BITS-1:0] cycle_cnt
);

    localparam int unsigned CHG_W  = cnt_width(CHARGE_MAX);
    localparam int unsigned DEAD_W = cnt_width(DEAD_CYCLES);
    localparam int unsigned DIS_W  = cnt_width(DIS_MAX);

    localparam logic [CHG_W-1:0]  CHG_LAST     = CHG_W'(CHARGE_MAX - 1);
    localparam logic [CHG_W-1:0]  CHG_SAT      = CHG_W'(CHARGE_MAX);
    localparam logic [DEAD_W-1:0] DEAD_LAST    = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_SAT     = DEAD_W'(DEAD_CYCLES);
    localparam logic [DIS_W-1:0]  DIS_MIN_LAST = DIS_W'(DIS_CYCLES - 1);
    localparam logic [DIS_W-1:0]  DIS_LAST     = DIS_W'(DIS_MAX - 1);
    localparam logic [DIS_W-1:0]  DIS_SAT      = DIS_W'(DIS_MAX);

    logic ant_in_s;

    sync_2ff u_sync_ant_in (
        .clk   (clk_100),
        .reset (reset),
        .d     (ant_in),
        .q     (ant_in_s)
    );

    tc_state_e           state_q, state_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [CHG_W-1:0]    chg_cnt_q, chg_cnt_d;
    logic [DIS_W-1:0]    dis_cnt_q, dis_cnt_d;
    logic [CNT_BITS-1:0] cycle_cnt_q, cycle_cnt_d;
    logic                ant_out_q, ant_out_d;
    logic                ant_dis_q, ant_dis_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic                dis_fault_q, dis_fault_d;
    logic                dis_exit;

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        timeout_d   = 1'b0;
        dis_fault_d = 1'b0;
        dis_exit    = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StDeadC;
                end
            end
            StDeadC: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = StCharge;
                end
            end
            StCharge: begin
                // meas_valid beats an abort, and an abort suppresses the timeout pulse.
                if (meas_valid) begin
                    state_d = StDeadD;
                end else if (!enable) begin
                    state_d = StDeadD;
                end else if (chg_cnt_q == CHG_LAST) begin
                    state_d   = StDeadD;
                    timeout_d = 1'b1;
                end
            end
            StDeadD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = StDischarge;
                end
            end
            StDischarge: begin
                if (dis_cnt_q == DIS_LAST) begin
                    dis_exit    = 1'b1;
                    dis_fault_d = ant_in_s;
                end else if ((dis_cnt_q >= DIS_MIN_LAST) && !ant_in_s) begin
                    dis_exit = 1'b1;
                end
                if (dis_exit) begin
                    state_d = enable ? StDeadC : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Phase counters restart at 0 on every state entry and saturate rather than wrap.
    always_comb begin
        dead_cnt_d = '0;
        chg_cnt_d  = '0;
        dis_cnt_d  = '0;

        if ((state_q == StDeadC || state_q == StDeadD) && (state_d == state_q)) begin
            dead_cnt_d = (dead_cnt_q == DEAD_SAT) ? dead_cnt_q : dead_cnt_q + DEAD_W'(1);
        end
        if ((state_q == StCharge) && (state_d == StCharge)) begin
            chg_cnt_d = (chg_cnt_q == CHG_SAT) ? chg_cnt_q : chg_cnt_q + CHG_W'(1);
        end
        if ((state_q == StDischarge) && (state_d == StDischarge)) begin
            dis_cnt_d = (dis_cnt_q == DIS_SAT) ? dis_cnt_q : dis_cnt_q + DIS_W'(1);
        end
    end

    // Drives are decoded from the next state so the registered pins track the state
    // register exactly; the dead states keep both drives low.
    always_comb begin
        ant_out_d   = (state_d == StCharge);
        ant_dis_d   = (state_d == StIdle) || (state_d == StDischarge);
        busy_d      = (state_d != StIdle);
        cycle_cnt_d = dis_exit ? cycle_cnt_q + CNT_BITS'(1) : cycle_cnt_q;
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q     <= StIdle;
            dead_cnt_q  <= '0;
            chg_cnt_q   <= '0;
            dis_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            ant_out_q   <= 1'b0;
            ant_dis_q   <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            dis_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dead_cnt_q  <= dead_cnt_d;
            chg_cnt_q   <= chg_cnt_d;
            dis_cnt_q   <= dis_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            ant_out_q   <= ant_out_d;
            ant_dis_q   <= ant_dis_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            dis_fault_q <= dis_fault_d;
        end
    end

    assign ant_out   = ant_out_q;
    assign ant_dis   = ant_dis_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign dis_fault = dis_fault_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_tc_excite.sv
// Bench for tc_excite: a table of excitation cycles is driven one after another; each
// record's expected phase lengths and pulses are queued when driven and checked by a
// negedge monitor when the DUT reports the cycle complete. Hand-written sequences cover
// reset, start latency, stray meas_valid and the idle return.
module tb_tc_excite;

    localparam int DEAD = 4;

    logic        clk_100 = 1'b0;
    logic        reset;
    logic        enable;
    logic        ant_in;
    logic        meas_valid;
    logic        ant_out;
    logic        ant_dis;
    logic        busy;
    logic        timeout;
    logic        dis_fault;
    logic [15:0] cycle_cnt;

    always #5 clk_100 = ~clk_100;

    tc_excite #(
        .CHARGE_MAX  (4095),
        .DEAD_CYCLES (4),
        .DIS_CYCLES  (1000),
        .DIS_MAX     (8191),
        .CNT_BITS    (16)
    ) dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .enable     (enable),
        .ant_in     (ant_in),
        .meas_valid (meas_valid),
        .ant_out    (ant_out),
        .ant_dis    (ant_dis),
        .busy       (busy),
        .timeout    (timeout),
        .dis_fault  (dis_fault),
        .cycle_cnt  (cycle_cnt)
    );

    // meas_at/abort_at: charge-cycle index for meas_valid / enable drop (-1 = never).
    // hold: ant_in high until that discharge-cycle index (-1 = low throughout).
    typedef struct {
        int id;
        int meas_at;
        int abort_at;
        int hold;
        bit en_next;
        int exp_chg;
        bit exp_to;
        int exp_dis;
        bit exp_fault;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   overlap_cnt = 0;
    vec_t exp_q[$];
    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    // Monitor: measures phase lengths from the pins and scores each completed cycle.
    int          ph, low_cnt, dc, chg, dd, dis, to_cnt, fault_cnt, exp_cc;
    bit          to_at_fall, fault_at_end;
    logic [15:0] last_cc;

    always @(negedge clk_100) begin
        if (reset) begin
            ph = 0; low_cnt = 0; dc = 0; chg = 0; dd = 0; dis = 0;
            to_cnt = 0; fault_cnt = 0; exp_cc = 0; last_cc = '0;
            to_at_fall = 0; fault_at_end = 0;
        end else begin
            assert (!(ant_out && ant_dis))
                else $error("FAIL overlap: ant_out and ant_dis both high");
            if (ant_out && ant_dis) overlap_cnt++;
            if (timeout) to_cnt++;
            if (dis_fault) fault_cnt++;
            case (ph)
                0: begin
                    if (ant_out) begin
                        ph = 1; dc = low_cnt; chg = 1;
                    end else if (!ant_dis) begin
                        low_cnt++;
                    end else begin
                        low_cnt = 0;
                    end
                end
                1: begin
                    if (ant_out) chg++;
                    else begin
                        ph = 2; dd = 1; to_at_fall = timeout;
                    end
                end
                2: begin
                    if (ant_dis) begin
                        ph = 3; dis = 1;
                    end else begin
                        dd++;
                    end
                end
                default: begin
                    if (cycle_cnt != last_cc) begin
                        fault_at_end = dis_fault;
                        if (exp_q.size() == 0) begin
                            check("unexpected_cycle_end", 1, 0);
                        end else begin
                            vec_t e;
                            e = exp_q.pop_front();
                            exp_cc++;
                            check($sformatf("v%0d dead_c", e.id), dc, DEAD);
                            check($sformatf("v%0d charge_len", e.id), chg, e.exp_chg);
                            check($sformatf("v%0d dead_d", e.id), dd, DEAD);
                            check($sformatf("v%0d timeout_cnt", e.id), to_cnt, e.exp_to);
                            check($sformatf("v%0d timeout_pos", e.id), to_at_fall, e.exp_to);
                            check($sformatf("v%0d dis_len", e.id), dis, e.exp_dis);
                            check($sformatf("v%0d fault_cnt", e.id), fault_cnt, e.exp_fault);
                            check($sformatf("v%0d fault_pos", e.id), fault_at_end,
                                  e.exp_fault);
                            check($sformatf("v%0d cycle_cnt", e.id), cycle_cnt, exp_cc);
                        end
                        ph = 0; low_cnt = ant_dis ? 0 : 1;
                        to_cnt = 0; fault_cnt = 0;
                    end else begin
                        dis++;
                    end
                end
            endcase
            last_cc = cycle_cnt;
        end
    end

    task automatic run_vec(input vec_t v);
        int          k;
        bit          done;
        logic [15:0] start_cc;
        exp_q.push_back(v);
        enable   = 1'b1;
        ant_in   = (v.hold >= 0);
        start_cc = cycle_cnt;
        k = 0;
        while (!ant_out && k < 200) begin
            tick(); k++;
        end
        if (!ant_out) check($sformatf("v%0d wait_charge", v.id), 0, 1);
        k = 0; done = 0;
        while (!done && k < 5000) begin
            meas_valid = (k == v.meas_at);
            if (k == v.abort_at) enable = 1'b0;
            tick();
            meas_valid = 1'b0;
            k++;
            done = !ant_out;
        end
        if (!done) check($sformatf("v%0d charge_end", v.id), 0, 1);
        k = 0;
        while (!ant_dis && k < 50) begin
            tick(); k++;
        end
        enable = v.en_next;
        k = 0; done = 0;
        while (!done && k < 10000) begin
            if (k == v.hold) ant_in = 1'b0;
            tick();
            k++;
            done = (cycle_cnt != start_cc);
        end
        ant_in = 1'b0;
        if (!done) check($sformatf("v%0d discharge_end", v.id), 0, 1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{0,  200,  -1,    -1, 1,  201, 0, 1000, 0};
        vecs[1]  = '{1,   -1,  -1,    -1, 1, 4095, 1, 1000, 0};
        vecs[2]  = '{2, 4094,  -1,    -1, 1, 4095, 0, 1000, 0};
        vecs[3]  = '{3,    0,  -1,    -1, 1,    1, 0, 1000, 0};
        vecs[4]  = '{4,   10,  -1,  1100, 1,   11, 0, 1103, 0};
        vecs[5]  = '{5,    7,  -1,   997, 1,    8, 0, 1000, 0};
        vecs[6]  = '{6,    7,  -1,   998, 1,    8, 0, 1001, 0};
        vecs[7]  = '{7,    5,  -1, 20000, 1,    6, 0, 8191, 1};
        vecs[8]  = '{8,    3,   3,    -1, 1,    4, 0, 1000, 0};
        vecs[9]  = '{9,   -1, 4094,   -1, 1, 4095, 0, 1000, 0};
        vecs[10] = '{10,  -1,  50,    -1, 0,   51, 0, 1000, 0};
        vecs[11] = '{11,  20,  -1,    -1, 0,   21, 0, 1000, 0};

        reset = 1'b1; enable = 1'b0; ant_in = 1'b0; meas_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst ant_out", ant_out, 0);
        check("rst ant_dis", ant_dis, 1);
        check("rst busy", busy, 0);
        check("rst timeout", timeout, 0);
        check("rst dis_fault", dis_fault, 0);
        check("rst cycle_cnt", cycle_cnt, 0);

        // meas_valid in idle must not start anything.
        meas_valid = 1'b1;
        repeat (3) tick();
        meas_valid = 1'b0;
        tick();
        check("idle meas busy", busy, 0);
        check("idle meas ant_dis", ant_dis, 1);

        // Start latency, with a stray meas_valid during the leading dead time.
        enable = 1'b1;
        n = 0;
        while (!ant_out && n < 20) begin
            tick(); n++;
            meas_valid = (n == 2);
        end
        meas_valid = 1'b0;
        check("start latency", n, DEAD + 1);
        check("start ant_dis", ant_dis, 0);
        check("start busy", busy, 1);
        repeat (10) tick();
        check("charge held", ant_out, 1);

        // Reset mid-charge returns every output to its reset value on the next edge.
        reset = 1'b1;
        tick();
        check("midrst ant_out", ant_out, 0);
        check("midrst ant_dis", ant_dis, 1);
        check("midrst busy", busy, 0);
        check("midrst timeout", timeout, 0);
        check("midrst dis_fault", dis_fault, 0);
        check("midrst cycle_cnt", cycle_cnt, 0);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
            if (!vecs[i].en_next) begin
                repeat (3) tick();
                check($sformatf("v%0d idle busy", i), busy, 0);
                check($sformatf("v%0d idle ant_dis", i), ant_dis, 1);
                check($sformatf("v%0d idle ant_out", i), ant_out, 0);
            end
        end

        repeat (5) tick();
        check("scoreboard drained", exp_q.size(), 0);
        check("drive overlap", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
